// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matrix-multiply host sequencer.
package matmul_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_MATRIX_SIZE = 1024;

  typedef enum logic [2:0] {
    LOAD_X,
    LOAD_Y,
    START,
    WAIT,
    DRAIN
  } host_io_state_t;

endpackage

// File: rtl/matmul_out_fifo.sv
// Two-entry synchronous result FIFO; push and pop may occur in the same cycle.
module matmul_out_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);
  assign count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/matmul_host_io.sv
// Host sequencer: streams X/Y into the engine BRAMs, pulses start, drains Z to the output stream.
// Optional cycle counter for the WAIT phase is enabled with MATMUL_HOST_IO_PERF_EN.
module matmul_host_io
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic                  x_wr_en,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic                  y_wr_en,
  output logic                  start,
  input  logic                  done,
  output logic [ADDR_WIDTH-1:0] z_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef MATMUL_HOST_IO_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int            CW   = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MSZ  = CW'(MATRIX_SIZE);
  localparam logic [CW-1:0] LAST = CW'(MATRIX_SIZE - 1);

  host_io_state_t        state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         pop_cnt_q, pop_cnt_d;
  logic                  inflight_q;
  logic                  ld_hs, rd_issue, pop;
  logic [1:0]            fifo_cnt;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] fifo_dout;

  matmul_out_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (inflight_q),
    .data_i  (z_dout),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .count_o (fifo_cnt)
  );

  // A same-cycle pop frees its slot, which keeps drain at one word per cycle.
  assign occ = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop_cnt_d = pop_cnt_q;
    in_ready  = reset && (state_q == LOAD_X || state_q == LOAD_Y);
    ld_hs     = in_valid && in_ready;
    x_wr_en   = ld_hs && (state_q == LOAD_X);
    y_wr_en   = ld_hs && (state_q == LOAD_Y);
    x_addr    = x_wr_en ? cnt_q[ADDR_WIDTH-1:0] : '0;
    y_addr    = y_wr_en ? cnt_q[ADDR_WIDTH-1:0] : '0;
    x_din     = x_wr_en ? in_data : '0;
    y_din     = y_wr_en ? in_data : '0;
    start     = reset && (state_q == START);
    z_addr    = reset ? cnt_q[ADDR_WIDTH-1:0] : '0;
    out_valid = reset && (fifo_cnt != 2'd0);
    out_data  = reset ? fifo_dout : '0;
    pop       = out_valid && out_ready;
    busy      = reset && !(state_q == LOAD_X && cnt_q == '0);
    rd_issue  = reset && (state_q == DRAIN) && (cnt_q < MSZ) && (occ < 3'd2);

    case (state_q)
      LOAD_X, LOAD_Y: begin
        if (ld_hs) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = (state_q == LOAD_X) ? LOAD_Y : START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      START: state_d = WAIT;
      WAIT:  if (done) state_d = DRAIN;
      DRAIN: begin
        if (rd_issue) cnt_d = cnt_q + 1'b1;
        if (pop) begin
          if (pop_cnt_q == LAST) begin
            state_d   = LOAD_X;
            cnt_d     = '0;
            pop_cnt_d = '0;
          end else begin
            pop_cnt_d = pop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD_X;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= LOAD_X;
      cnt_q      <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      inflight_q <= rd_issue;
    end
  end

`ifdef MATMUL_HOST_IO_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clock) begin
    if (!reset)                                  perf_q <= '0;
    else if (state_d == START && state_q != START) perf_q <= '0;
    else if (state_q == WAIT && perf_q != '1)    perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = reset ? perf_q : '0;
`endif

endmodule

// File: tb/tb_matmul_host_io.sv
// Scoreboard bench for matmul_host_io with a 4-word matrix on a 2-bit address space.
module tb_matmul_host_io;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int MS = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] x_addr, y_addr, z_addr;
  logic [DW-1:0] x_din, y_din, z_dout, out_data;
  logic          x_wr_en, y_wr_en, start, done;
  logic          out_valid, out_ready, busy;
`ifdef MATMUL_HOST_IO_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  matmul_host_io #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATRIX_SIZE(MS)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x_addr(x_addr), .x_din(x_din), .x_wr_en(x_wr_en),
    .y_addr(y_addr), .y_din(y_din), .y_wr_en(y_wr_en),
    .start(start), .done(done), .z_addr(z_addr), .z_dout(z_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef MATMUL_HOST_IO_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Z BRAM model: one-cycle read latency, contents 100+addr.
  always @(posedge clock) z_dout <= 32'd100 + 32'(z_addr);

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_x[$], exp_y[$];
  logic [31:0] exp_out[$];
  int checks = 0, errors = 0;
  int start_cnt = 0, out_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected event at %0t", nm, $time);
  endtask

  // Monitor: compares every write and every output handshake against the queues.
  always @(negedge clock) begin
    wr_t e;
    if (x_wr_en) begin
      if (exp_x.size() == 0) unexpected("x_write");
      else begin
        e = exp_x.pop_front();
        check("x_addr", 32'(x_addr), e.a);
        check("x_din", x_din, e.d);
      end
    end
    if (y_wr_en) begin
      if (exp_y.size() == 0) unexpected("y_write");
      else begin
        e = exp_y.pop_front();
        check("y_addr", 32'(y_addr), e.a);
        check("y_din", y_din, e.d);
      end
    end
    if (start) start_cnt++;
    if (out_valid && out_ready) begin
      out_cnt++;
      if (exp_out.size() == 0) unexpected("out_word");
      else check("out_data", out_data, exp_out.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_out();
    for (int i = 0; i < MS; i++) exp_out.push_back(32'd100 + 32'(i));
  endtask

  // Streams words base+1..base+8; returns in the START cycle.
  task automatic load(input int base, input bit gaps);
    for (int k = 0; k < 2 * MS; k++) begin
      if (k < MS) exp_x.push_back('{32'(k), 32'(base + k + 1)});
      else        exp_y.push_back('{32'(k - MS), 32'(base + k + 1)});
    end
    for (int k = 0; k < 2 * MS; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 32'hdead;
        @(negedge clock);
        check("gap_in_ready", in_ready, 1);
        tick();
      end
      in_valid = 1'b1;
      in_data  = 32'(base + k + 1);
      @(negedge clock);
      check("load_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b1; in_data = 32'd9; done = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_x_wr_en", x_wr_en, 0);
    tick();
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    tick();

    // Run 1: back-to-back load, early done, streaming drain.
    load(0, 1'b0);
    done = 1'b1;
    @(negedge clock);
    check("r1_start", start, 1);
    check("r1_start_in_ready", in_ready, 0);
    tick();
    done = 1'b0;
    @(negedge clock);
    check("r1_start_once", start, 0);
    check("r1_wait_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clock);
      check("r1_early_done_ignored", out_valid, 0);
    end
    tick();
    done = 1'b1;
    push_out();
    @(negedge clock);
    check("r1_wait_last", out_valid, 0);
    tick();
    done = 1'b0;
    @(negedge clock);
    check("r1_d0_valid", out_valid, 0);
    check("r1_d0_zaddr", 32'(z_addr), 0);
    tick();
    @(negedge clock);
    check("r1_d1_valid", out_valid, 0);
    for (int i = 0; i < MS; i++) begin
      tick();
      @(negedge clock);
      check("r1_stream_valid", out_valid, 1);
    end
    tick();
    @(negedge clock);
    check("r1_idle_busy", busy, 0);
    check("r1_idle_in_ready", in_ready, 1);
    check("r1_out_cnt", out_cnt, 4);
    tick();

    // Run 2: gapped load, in_valid ignored outside load, backpressure.
    load(0, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'd77;
    @(negedge clock);
    check("r2_start", start, 1);
    tick();
    done = 1'b1;
    out_ready = 1'b0;
    push_out();
    tick();
    done = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("r2_bp_valid", out_valid, 1);
      check("r2_bp_hold", out_data, 100);
      tick();
    end
    @(negedge clock);
    check("r2_bp_zaddr", 32'(z_addr), 2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_cnt < 8; i++) tick();
    check("r2_out_cnt", out_cnt, 8);
    @(negedge clock);
    check("r2_idle_busy", busy, 0);
    tick();

    // Run 3: reset after three X words, then a clean run with a 7-cycle WAIT.
    for (int k = 0; k < 3; k++) begin
      exp_x.push_back('{32'(k), 32'(11 + k)});
      in_valid = 1'b1;
      in_data  = 32'(11 + k);
      tick();
    end
    reset = 1'b0;
    in_data = 32'd55;
    @(negedge clock);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_x_wr_en", x_wr_en, 0);
    check("mid_rst_x_addr", 32'(x_addr), 0);
    check("mid_rst_x_din", x_din, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_start", start, 0);
    tick();
    reset = 1'b1;
    in_valid = 1'b0;
    load(20, 1'b0);
    @(negedge clock);
    check("r3_start", start, 1);
    tick();
    for (int i = 0; i < 6; i++) tick();
    done = 1'b1;
    push_out();
    tick();
    done = 1'b0;
`ifdef MATMUL_HOST_IO_PERF_EN
    @(negedge clock);
    check("perf_cycles", perf_cycles, 7);
`endif
    for (int i = 0; i < 20 && out_cnt < 12; i++) tick();
    check("r3_out_cnt", out_cnt, 12);
    @(negedge clock);
    check("r3_idle_busy", busy, 0);
    check("start_count", start_cnt, 3);
    check("x_queue_empty", exp_x.size(), 0);
    check("y_queue_empty", exp_y.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_host_io.md
# matmul_host_io

Host-side sequencer for the matrix-multiply engine. It loads the X and Y operand BRAMs from an input stream and pulses `start` to the engine. It then waits for `done`, reads the Z result BRAM back, and emits the results on an output stream. It sits between the system streaming fabric and the engine's three BRAMs: it writes X and Y, and reads Z.

## Interface
- `DATA_WIDTH`, 32, word width of all matrices and streams
- `ADDR_WIDTH`, 10, BRAM address width
- `MATRIX_SIZE`, 1024, words per matrix; must be ≤ 2**ADDR_WIDTH

Ports:
- `clock`  in  1  single clock; all logic rising-edge
- `reset`  in  1  synchronous, active-low
- `in_data`  in  DATA_WIDTH  operand word
- `in_valid`  in  1  operand word valid
- `in_ready`  out  1  block accepts an operand word
- `x_addr`, `y_addr`  out  ADDR_WIDTH  operand write addresses
- `x_din`, `y_din`  out  DATA_WIDTH  operand write data
- `x_wr_en`, `y_wr_en`  out  1  operand write strobes
- `start`  out  1  one-cycle pulse to the engine
- `done`  in  1  engine completion, level or pulse
- `z_addr`  out  ADDR_WIDTH  result read address
- `z_dout`  in  DATA_WIDTH  result read data, valid 1 cycle after `z_addr`
- `out_data`  out  DATA_WIDTH  result word
- `out_valid`  out  1  result word valid
- `out_ready`  in  1  downstream accepts a result word
- `busy`  out  1  high in every state except LOAD_X with word count 0

## Operation
- State machine: LOAD_X → LOAD_Y → START → WAIT → DRAIN → LOAD_X.
- **LOAD_X**
  - `in_ready`=1.
  - A handshake (`in_valid & in_ready`) drives `x_wr_en`=1, `x_din`=`in_data`, `x_addr`=word count in the same cycle.
  - The count increments on each handshake. After word `MATRIX_SIZE`-1, the count clears and the state goes to LOAD_Y.
- **LOAD_Y**
  - Identical to LOAD_X, using the `y_*` ports.
  - After word `MATRIX_SIZE`-1, the state goes to START.
- **START**
  - `in_ready`=0, `start`=1 for exactly this cycle.
  - Next state is WAIT.
- **WAIT**
  - `done` is sampled here only; a high `done` in START is ignored.
  - On the first cycle `done`=1, the state goes to DRAIN.
- **DRAIN**
  - A read counter walks `z_addr` from 0 to `MATRIX_SIZE`-1.
  - A read is issued only when (FIFO occupancy + reads in flight) < 2, so no result word is ever dropped.
  - Returned `z_dout` is pushed into a 2-entry output FIFO. `out_valid` means the FIFO is non-empty; a pop happens on `out_valid & out_ready`.
  - After `MATRIX_SIZE` words are popped, the state goes to LOAD_X and all counters clear.
- Counters are ADDR_WIDTH+1 bits wide so that `MATRIX_SIZE`=2**ADDR_WIDTH terminates correctly. Addresses take the low ADDR_WIDTH bits.
- `in_valid` outside the LOAD states is ignored, and no data is consumed.

## Timing
- While `reset`=0, all outputs are 0 (including `in_ready`, `start`, write enables and `out_valid`), the state is LOAD_X and counters and FIFO are cleared.
- The first cycle after `reset` rises has `in_ready`=1.
- Load throughput is one word per cycle, with zero write latency: the BRAM write happens in the handshake cycle.
- `start` rises in the cycle after the last Y handshake.
- The first `z_addr` is issued in the first DRAIN cycle.
- First `out_valid` appears 2 cycles after entering DRAIN.
- With `out_ready` held at 1, sustained output is one word per cycle.
- Backpressure: when `out_ready`=0, at most 2 words are buffered. `out_data` is held stable while `out_valid & !out_ready`.
- Reset asserted mid-operation aborts immediately. Nothing is written after the reset cycle, and no `start` is produced.

## Configuration
- **`MATMUL_HOST_IO_PERF_EN` defined**
  - Adds output port `perf_cycles` (32 bits).
  - Clears on entry to START and increments every WAIT cycle, saturating at all-ones.
  - Holds its value until the next START. Reset value is 0.
- **Undefined:** the port and the counter are absent; all other behaviour is identical.

## Structure
- A shared package `matmul_pkg` holds:
  - the state enum `host_io_state_t` (LOAD_X, LOAD_Y, START, WAIT, DRAIN);
  - the default width constants.
- Sub-module `matmul_out_fifo`: 2-entry synchronous FIFO parameterized by DATA_WIDTH, with push/pop/count, using the same clock and active-low reset. The top level keeps the FSM, counters and in-flight tracking.

## Test plan
Directed scenarios use `MATRIX_SIZE`=4.
- **Load:** stream words 1..8 with `in_valid` held high. Expect `x_wr_en` on addresses 0–3 with data 1–4, then `y_wr_en` on addresses 0–3 with data 5–8, then `start` high for exactly 1 cycle, one cycle after the word-8 handshake.
- **Load gaps:** toggle `in_valid` every other cycle. Expect only 8 writes total, with the address sequence unchanged.
- **Drain:** the model returns `z_dout`=100+addr. With `done` pulsed and `out_ready` held at 1, expect `out_data` 100, 101, 102, 103 on consecutive cycles starting 2 cycles after DRAIN entry; the state then returns to LOAD_X and `busy` goes to 0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles during DRAIN. Expect at most 2 reads outstanding, `out_data`=100 held stable, no words lost, and all 4 words delivered after release.
- **Early done:** `done`=1 during the START cycle, then 0 for 5 cycles, then 1. Expect DRAIN entered only after the second assertion.
- **Mid-operation reset:** assert `reset`=0 after 3 X words. Expect all outputs 0 the next cycle and a fresh load to start writing at `x_addr`=0. With the PERF macro defined, a 7-cycle WAIT must give `perf_cycles`=7.
